// File: rtl/ntt_bfly_pipe_pkg.sv
// Shared constants and mod-Q add/sub helpers for the NTT processing elements.
// Q = 2^(LOGQ-1)+1, so 2^(LOGQ-1) = -1 (mod Q) drives the reduction.
package ntt_bfly_pipe_pkg;

  localparam int unsigned LOGQ = 9;
  localparam int unsigned Q    = 257;
  localparam int unsigned HALF = LOGQ - 1;
  localparam int unsigned PW   = 2 * LOGQ;

  localparam logic [LOGQ:0]   QE = (LOGQ + 1)'(Q);
  localparam logic [LOGQ-1:0] QN = LOGQ'(Q);

  // Inputs must be < Q; result is canonical.
  function automatic logic [LOGQ-1:0] add_mod(input logic [LOGQ-1:0] a,
                                              input logic [LOGQ-1:0] b);
    logic [LOGQ:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QE) begin
      s = s - QE;
    end
    return s[LOGQ-1:0];
  endfunction

  // Wraps mod 2^LOGQ first; adding Q then lands exactly on a-b+Q.
  function automatic logic [LOGQ-1:0] sub_mod(input logic [LOGQ-1:0] a,
                                              input logic [LOGQ-1:0] b);
    logic [LOGQ-1:0] d;
    d = a - b;
    if (a < b) begin
      d = d + QN;
    end
    return d;
  endfunction

endpackage

// File: rtl/ntt_bfly_pipe_modred_q.sv
// Combinational 2*LOGQ-bit to canonical mod-Q reduction using 2^(LOGQ-1) = -1 (mod Q):
// p = c2*2^(2H) + c1*2^H + c0  ==  c0 - c1 + c2  (mod Q), then one fold either way.
module ntt_modred_q
  import ntt_bfly_pipe_pkg::*;
(
  input  logic [PW-1:0]   p_i,
  output logic [LOGQ-1:0] r_o
);

  localparam int unsigned TW = LOGQ + 2;
  localparam logic signed [TW-1:0] QS = TW'(Q);

  logic signed [TW-1:0] e0, e1, e2, t;
  logic unused_hi;

  always_comb begin
    e0 = '0;
    e1 = '0;
    e2 = '0;
    e0[HALF-1:0]        = p_i[HALF-1:0];
    e1[HALF-1:0]        = p_i[2*HALF-1:HALF];
    e2[PW-2*HALF-1:0]   = p_i[PW-1:2*HALF];
    t = e0 - e1 + e2;
    if (t < 0) begin
      t = t + QS;
    end else if (t >= QS) begin
      t = t - QS;
    end
  end

  assign r_o       = t[LOGQ-1:0];
  assign unused_hi = ^t[TW-1:LOGQ];

endmodule

// File: rtl/ntt_bfly_pipe.sv
// Three-stage Cooley-Tukey butterfly mod Q with valid/ready on both sides.
// Define NTT_BFLY_INTT_MODE_EN to add in_inv and per-beat Gentleman-Sande mode.
module ntt_bfly_pipe
  import ntt_bfly_pipe_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  in_a,
  input  logic [LOGQ-1:0]  in_b,
  input  logic [LOGQ-1:0]  in_w,
  input  logic [TAG_W-1:0] in_tag,
`ifdef NTT_BFLY_INTT_MODE_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  out_x,
  output logic [LOGQ-1:0]  out_y,
  output logic [TAG_W-1:0] out_tag
);

  // Stage-2 payload: reduced product (forward) or full product awaiting reduction (inverse).
`ifdef NTT_BFLY_INTT_MODE_EN
  localparam int unsigned M2W = PW;
`else
  localparam int unsigned M2W = LOGQ;
`endif

  logic en;

  logic             v1_q, v1_d;
  logic [LOGQ-1:0]  a1_q, a1_d;
  logic [PW-1:0]    p1_q, p1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic             v2_q, v2_d;
  logic [LOGQ-1:0]  a2_q, a2_d;
  logic [M2W-1:0]   m2_q, m2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             v3_q, v3_d;
  logic [LOGQ-1:0]  x3_q, x3_d;
  logic [LOGQ-1:0]  y3_q, y3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic [LOGQ-1:0]  r2;

`ifdef NTT_BFLY_INTT_MODE_EN
  logic             inv1_q, inv1_d;
  logic             inv2_q, inv2_d;
  logic [LOGQ-1:0]  w1_q, w1_d;
  logic [LOGQ-1:0]  r3;

  ntt_modred_q u_red_s3 (
    .p_i (m2_q),
    .r_o (r3)
  );
`endif

  ntt_modred_q u_red_s2 (
    .p_i (p1_q),
    .r_o (r2)
  );

  always_comb begin
    en     = !v3_q || out_ready;
    v1_d   = v1_q;
    a1_d   = a1_q;
    p1_d   = p1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    a2_d   = a2_q;
    m2_d   = m2_q;
    tag2_d = tag2_q;
    v3_d   = v3_q;
    x3_d   = x3_q;
    y3_d   = y3_q;
    tag3_d = tag3_q;
`ifdef NTT_BFLY_INTT_MODE_EN
    inv1_d = inv1_q;
    inv2_d = inv2_q;
    w1_d   = w1_q;
`endif
    if (en) begin
      v1_d   = in_valid;
      a1_d   = in_a;
      p1_d   = PW'(in_b) * PW'(in_w);
      tag1_d = in_tag;

      v2_d   = v1_q;
      a2_d   = a1_q;
      m2_d   = M2W'(r2);
      tag2_d = tag1_q;

      v3_d   = v2_q;
      x3_d   = add_mod(a2_q, m2_q[LOGQ-1:0]);
      y3_d   = sub_mod(a2_q, m2_q[LOGQ-1:0]);
      tag3_d = tag2_q;
`ifdef NTT_BFLY_INTT_MODE_EN
      inv1_d = in_inv;
      w1_d   = in_w;
      inv2_d = inv1_q;
      if (in_inv) begin
        a1_d = add_mod(in_a, in_b);
        p1_d = PW'(sub_mod(in_a, in_b));
      end
      if (inv1_q) begin
        m2_d = PW'(p1_q[LOGQ-1:0]) * PW'(w1_q);
      end
      if (inv2_q) begin
        x3_d = a2_q;
        y3_d = r3;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      p1_q   <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      a2_q   <= '0;
      m2_q   <= '0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      x3_q   <= '0;
      y3_q   <= '0;
      tag3_q <= '0;
`ifdef NTT_BFLY_INTT_MODE_EN
      inv1_q <= 1'b0;
      inv2_q <= 1'b0;
      w1_q   <= '0;
`endif
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      p1_q   <= p1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      a2_q   <= a2_d;
      m2_q   <= m2_d;
      tag2_q <= tag2_d;
      v3_q   <= v3_d;
      x3_q   <= x3_d;
      y3_q   <= y3_d;
      tag3_q <= tag3_d;
`ifdef NTT_BFLY_INTT_MODE_EN
      inv1_q <= inv1_d;
      inv2_q <= inv2_d;
      w1_q   <= w1_d;
`endif
    end
  end

  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_x     = x3_q;
  assign out_y     = y3_q;
  assign out_tag   = tag3_q;

endmodule
